// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with single-cycle flush, occupancy count and full/empty flags
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; flush discards everything in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is written only on an accepted push, so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC, credit-limited imem requests, PC tagging and decode-side buffering
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_target,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_next;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] entry_count;
    logic [CW:0]   occupancy;
    logic          tag_full;
    logic          tag_empty;
    logic          entry_full;
    logic          entry_empty;
    logic [31:0]   tag_head;
    fetch_entry_t  entry_in;
    fetch_entry_t  entry_head;
    logic          accept;
    logic          resp;
    logic          keep;
    logic          pop;

    // Credit covers both outstanding requests and buffered entries, so the buffer cannot overflow
    assign occupancy = {1'b0, in_flight} + {1'b0, entry_count};
    assign imem_req  = !rst && !ex_redirect && occupancy < (CW+1)'(FIFO_DEPTH);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign resp      = imem_rvalid && in_flight != '0;
    assign keep      = resp && drop_cnt == '0 && !ex_redirect;
    assign if_valid  = !entry_empty && !ex_redirect;
    assign pop       = if_valid && !id_stall;
    assign if_instr  = if_valid ? entry_head.instr : NOP_INSTR;
    assign if_pc     = if_valid ? entry_head.pc : '0;
    assign entry_in  = '{pc: tag_head, instr: imem_rdata};

    // PC of every live request; dropped responses have had their tags flushed already
    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (keep),
        .flush (ex_redirect),
        .din   (fetch_pc),
        .dout  (tag_head),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_entry_q (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .flush (ex_redirect),
        .din   (entry_in),
        .dout  (entry_head),
        .count (entry_count),
        .full  (entry_full),
        .empty (entry_empty)
    );

    // Next PC and counters; a redirect marks every response still owed (net of this cycle's) for dropping
    always_comb begin
        fetch_pc_next  = ex_redirect ? word_align(ex_redirect_target)
                       : accept      ? fetch_pc + 32'd4
                       :               fetch_pc;
        in_flight_next = in_flight + CW'(accept) - CW'(resp);
        drop_cnt_next  = ex_redirect               ? in_flight - CW'(resp)
                       : (resp && drop_cnt != '0)  ? drop_cnt - CW'(1)
                       :                             drop_cnt;
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            fetch_pc  <= fetch_pc_next;
            in_flight <= in_flight_next;
            drop_cnt  <= drop_cnt_next;
        end
    end

    // Interface and bookkeeping invariants
    a_addr_aligned: assert property (@(posedge clk) disable iff (rst) imem_addr[1:0] == 2'b00);
    a_credit:       assert property (@(posedge clk) disable iff (rst) occupancy <= (CW+1)'(FIFO_DEPTH));
    a_req_hold:     assert property (@(posedge clk) disable iff (rst)
                        imem_req && !imem_ready |=> ex_redirect || (imem_req && $stable(imem_addr)));
    a_rvalid_owed:  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> in_flight != '0);
    a_tag_room:     assert property (@(posedge clk) disable iff (rst) accept |-> !tag_full);
    a_tag_present:  assert property (@(posedge clk) disable iff (rst) keep |-> !tag_empty);
    a_entry_room:   assert property (@(posedge clk) disable iff (rst) keep |-> !entry_full);
    a_tags_track:   assert property (@(posedge clk) disable iff (rst) tag_count == in_flight - drop_cnt);

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench with an in-order imem model returning ~addr as the instruction
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ex_redirect;
    logic [31:0] ex_redirect_target;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    if_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ready         (imem_ready),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .ex_redirect        (ex_redirect),
        .ex_redirect_target (ex_redirect_target),
        .id_stall           (id_stall),
        .if_valid           (if_valid),
        .if_instr           (if_instr),
        .if_pc              (if_pc)
    );

    always #5 clk = ~clk;

    // Memory model: record accepted requests mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rst && imem_req && imem_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
    end

    // Memory model: present due responses in order just after each edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
        end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend_addr.pop_front();
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_next(input logic [31:0] pc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!if_valid && n < 20);
        checks++;
        assert (if_valid === 1'b1 && if_pc === pc && if_instr === ~pc) else begin
            errors++;
            $error("FAIL next_fetch: got valid=%0b pc=%h instr=%h expected pc=%h instr=%h",
                   if_valid, if_pc, if_instr, pc, ~pc);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        imem_ready = 1'b1;
        ex_redirect = 1'b0;
        ex_redirect_target = '0;
        id_stall = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP_INSTR);
        chk("rst_pc", if_pc, 32'd0);
        rst = 1'b0;
        #1;
        chk("run_req", 32'(imem_req), 32'd1);
        chk("run_addr", imem_addr, RPC);
        expect_next(RPC);
        expect_next(RPC + 32'd4);
        expect_next(RPC + 32'd8);
        id_stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc", if_pc, RPC + 32'd8);
        end
        chk("stall_req_full", 32'(imem_req), 32'd0);
        chk("stall_addr", imem_addr, RPC + 32'd16);
        id_stall = 1'b0;
        expect_next(RPC + 32'd12);
        imem_ready = 1'b0;
        repeat (4) begin
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, RPC + 32'd16);
        end
        imem_ready = 1'b1;
        expect_next(RPC + 32'd16);
        expect_next(RPC + 32'd20);
        lat = 3;
        tick();
        tick();
        chk("two_inflight_req", 32'(imem_req), 32'd0);
        chk("two_inflight_valid", 32'(if_valid), 32'd0);
        ex_redirect = 1'b1;
        ex_redirect_target = 32'h0000_0100;
        #1;
        chk("redir_req", 32'(imem_req), 32'd0);
        tick();
        chk("redir_addr", imem_addr, 32'h0000_0100);
        ex_redirect = 1'b0;
        lat = 1;
        expect_next(32'h0000_0100);
        expect_next(32'h0000_0104);
        n = 0;
        while (imem_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rvalid_seen", 32'(imem_rvalid), 32'd1);
        ex_redirect = 1'b1;
        ex_redirect_target = 32'h0000_0203;
        #1;
        chk("redir2_valid", 32'(if_valid), 32'd0);
        chk("redir2_instr", if_instr, NOP_INSTR);
        chk("redir2_pc", if_pc, 32'd0);
        chk("redir2_req", 32'(imem_req), 32'd0);
        tick();
        chk("redir2_addr", imem_addr, 32'h0000_0200);
        ex_redirect = 1'b0;
        expect_next(32'h0000_0200);
        expect_next(32'h0000_0204);
        ex_redirect = 1'b1;
        ex_redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
        ex_redirect = 1'b0;
        expect_next(32'hFFFF_FFFC);
        expect_next(32'h0000_0000);
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", imem_addr, RPC);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_instr", if_instr, NOP_INSTR);
        chk("midrst_pc", if_pc, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rerun_req", 32'(imem_req), 32'd1);
        chk("rerun_addr", imem_addr, RPC);
        expect_next(RPC);
        expect_next(RPC + 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
